ht_reset_seq: RTL



---
 rtl/ht_reset_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ht_reset_seq.sv
// Reset sequencer: stretches and staggers the platform/soft reset
// into NUM_CH pipelined, replicated active-high reset channels.
module ht_reset_seq #(
    parameter int NUM_CH  = 4,
    parameter int STRETCH = 8,
    parameter int STAGGER = 4,
    parameter int PIPE    = 2
) (
    input  logic              clkhx,
    input  logic              i_reset,
    input  logic              i_soft_reset,
    output logic [NUM_CH-1:0] o_reset,
    output logic              o_ready
);

    localparam int CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CH_W    = $clog2(NUM_CH + 1);

    localparam logic [CNT_W-1:0] STRETCH_C = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] STAGGER_C = CNT_W'(STAGGER);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    localparam bit ONE_SHOT = (NUM_CH == 1) || (STAGGER == 0);
    localparam logic [NUM_CH-1:0] REL0_MASK =
        ONE_SHOT ? {NUM_CH{1'b1}} : NUM_CH'(1);

    typedef enum logic [1:0] {
        HOLD,
        STRETCH_CNT,
        RELEASE,
        RUN
    } state_t;

    state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CH_W-1:0] ch_q;
    (* keep = "true" *) logic [NUM_CH-1:0] irst_q;

    logic rsrc;
    logic first_rel;
    logic [NUM_CH-1:0] ch_mask;

    assign rsrc = i_reset | i_soft_reset;

    // The first low cycle spent in HOLD already counts toward the stretch.
    assign first_rel =
        ((state_q == HOLD) && (STRETCH == 1)) ||
        ((state_q == STRETCH_CNT) && (cnt_q >= STRETCH_C));

    assign ch_mask = NUM_CH'(1) << ch_q;

    always_ff @(posedge clkhx) begin
        if (rsrc) begin
            state_q <= HOLD;
            irst_q  <= '1;
            cnt_q   <= '0;
            ch_q    <= '0;
        end else if (first_rel) begin
            irst_q  <= irst_q & ~REL0_MASK;
            ch_q    <= CH_ONE;
            cnt_q   <= CNT_ONE;
            state_q <= ONE_SHOT ? RUN : RELEASE;
        end else begin
            unique case (state_q)
                HOLD: begin
                    state_q <= STRETCH_CNT;
                    cnt_q   <= CNT_TWO;
                end
                STRETCH_CNT: begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
                RELEASE: begin
                    if (cnt_q >= STAGGER_C) begin
                        irst_q <= irst_q & ~ch_mask;
                        ch_q   <= ch_q + CH_ONE;
                        cnt_q  <= CNT_ONE;
                        if (ch_q == CH_LAST) begin
                            state_q <= RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    irst_q <= '0;
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    // Global reset bypasses the pipe so assertion is seen on the next edge.
    (* keep = "true" *) logic [NUM_CH-1:0] rst_pipe_q [PIPE];
    (* keep = "true" *) logic [PIPE-1:0] rdy_pipe_q;
    logic rdy_d;

    assign rdy_d = ~|irst_q;

    always_ff @(posedge clkhx) begin
        if (i_reset) begin
            for (int i = 0; i < PIPE; i++) begin
                rst_pipe_q[i] <= '1;
            end
            rdy_pipe_q <= '0;
        end else begin
            rst_pipe_q[0] <= irst_q;
            rdy_pipe_q[0] <= rdy_d;
            for (int i = 1; i < PIPE; i++) begin
                rst_pipe_q[i] <= rst_pipe_q[i-1];
                rdy_pipe_q[i] <= rdy_pipe_q[i-1];
            end
        end
    end

    assign o_reset = rst_pipe_q[PIPE-1];
    assign o_ready = rdy_pipe_q[PIPE-1];

endmodule
